pc_gen: RTL

Parametrised program-counter generator for the single-cycle RISC-V core. It replaces the fixed 32-bit next-PC logic. It adds correct two's-complement branch and JAL offsets, JALR, and full RV32I branch-condition decoding. It also adds a pipeline-freeze stall, trap and mret redirection with a saved exception PC, misaligned-target detection, and a saturating redirect counter. It sits between the decoder/ALU flags and the instruction-memory address port.

---
 rtl/pc_gen.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// Next-PC generator: sequential fetch, RV32I branches, JAL/JALR, trap/mret redirection,
// misaligned-target trapping and a saturating redirect counter.
module pc_gen #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
   parameter int unsigned     CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             branch,
   input  logic [2:0]       br_funct3,
   input  logic             zero,
   input  logic             lt,
   input  logic             ltu,
   input  logic             jal,
   input  logic             jalr,
   input  logic [XLEN-1:0]  imm,
   input  logic [XLEN-1:0]  rs1_val,
   input  logic             trap,
   input  logic             mret,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_plus4,
   output logic             taken,
   output logic [XLEN-1:0]  epc,
   output logic             misalign,
   output logic [CNT_W-1:0] redirect_cnt
);

   localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(32'd4);
   localparam logic [XLEN-1:0]  JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

   logic [XLEN-1:0]  pc_r;
   logic [XLEN-1:0]  epc_r;
   logic             misalign_r;
   logic [CNT_W-1:0] cnt_r;

   logic [XLEN-1:0]  pc_plus4_s;
   logic [XLEN-1:0]  br_tgt_s;
   logic [XLEN-1:0]  jalr_tgt_s;
   logic [XLEN-1:0]  tgt_s;
   logic [XLEN-1:0]  next_pc_s;
   logic             br_cond_s;
   logic             jump_s;
   logic             bad_tgt_s;
   logic             take_s;
   logic             save_epc_s;
   logic             set_mis_s;

   assign pc_plus4_s = pc_r + PC_STEP;
   assign br_tgt_s   = pc_r + imm;
   assign jalr_tgt_s = (rs1_val + imm) & JALR_MASK;

   // Branch condition decode from funct3 and the ALU compare flags
   always_comb begin
      case (br_funct3)
         3'b000:  br_cond_s = zero;
         3'b001:  br_cond_s = ~zero;
         3'b100:  br_cond_s = lt;
         3'b101:  br_cond_s = ~lt;
         3'b110:  br_cond_s = ltu;
         3'b111:  br_cond_s = ~ltu;
         default: br_cond_s = 1'b0;
      endcase
   end

   // Control-flow target selection among jalr > jal > taken branch
   always_comb begin
      jump_s = 1'b0;
      tgt_s  = pc_plus4_s;
      if (jalr) begin
         jump_s = 1'b1;
         tgt_s  = jalr_tgt_s;
      end else if (jal) begin
         jump_s = 1'b1;
         tgt_s  = br_tgt_s;
      end else if (branch && br_cond_s) begin
         jump_s = 1'b1;
         tgt_s  = br_tgt_s;
      end else begin
         jump_s = 1'b0;
         tgt_s  = pc_plus4_s;
      end
      bad_tgt_s = jump_s && (tgt_s[1:0] != 2'b00);
   end

   // Next-PC priority; a misaligned target only traps when the jump would actually be taken
   always_comb begin
      next_pc_s  = pc_plus4_s;
      take_s     = 1'b0;
      save_epc_s = 1'b0;
      set_mis_s  = 1'b0;
      if (trap) begin
         next_pc_s  = TRAP_VECTOR;
         take_s     = 1'b1;
         save_epc_s = 1'b1;
      end else if (mret) begin
         next_pc_s = epc_r;
         take_s    = 1'b1;
      end else if (stall) begin
         next_pc_s = pc_r;
      end else if (bad_tgt_s) begin
         next_pc_s  = TRAP_VECTOR;
         take_s     = 1'b1;
         save_epc_s = 1'b1;
         set_mis_s  = 1'b1;
      end else begin
         next_pc_s = tgt_s;
         take_s    = jump_s;
      end
   end

   // PC, exception PC, misalign pulse and saturating redirect counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_r       <= RESET_VECTOR;
         epc_r      <= {XLEN{1'b0}};
         misalign_r <= 1'b0;
         cnt_r      <= {CNT_W{1'b0}};
      end else begin
         pc_r       <= next_pc_s;
         misalign_r <= set_mis_s;
         if (save_epc_s) begin
            epc_r <= pc_r;
         end
         if (take_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   assign pc           = pc_r;
   assign pc_plus4     = pc_plus4_s;
   assign taken        = reset & take_s;
   assign epc          = epc_r;
   assign misalign     = misalign_r;
   assign redirect_cnt = cnt_r;

endmodule
